rstseq: RTL and testbench

RSTSEQ -- requirements
Module: rstseq

---
 rtl/rstseq_pkg.sv | 26 ++
 rtl/rstseq_sync.sv | 28 ++
 rtl/rstseq.sv | 163 ++++++++++++++++
 tb/tb_rstseq.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rstseq_pkg.sv
// rstseq_pkg -- shared types and constants for the reset sequencer.
//   state_e   : FSM state encodings (exported on the 3-bit state port)
//   CNT_W     : width of the per-state cycle counter
//   LOSS_W    : width of the saturating lock-loss counter
//   sat_inc() : saturating increment for the state counter
package rstseq_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LOSS_W = 8;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_STABLE = 3'd1,
    ST_WAKE   = 3'd2,
    ST_INIT   = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rstseq_sync.sv
// rstseq_sync -- two-flop single-bit synchronizer.
//   sys_clk : sampling clock
//   sys_rst : synchronous active-high reset, clears both flops
//   d_in    : asynchronous input
//   q_out   : synchronized output, two cycles of latency
module rstseq_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/rstseq.sv
// rstseq -- power-up / soft reset sequencer for flash, DDR PHY, memory
// controller and CPU.
//   sys_clk        in   sole clock
//   sys_rst        in   synchronous active-high reset
//   pll_locked     in   PLL lock, asynchronous (synchronized internally)
//   trigger_reset  in   soft-reset request
//   ddr_init_done  in   DDR init engine complete
//   norflash_rst_n out  flash reset, active-low
//   phy_rst        out  DDR PHY reset
//   ctl_rst        out  memory controller reset
//   cpu_rst        out  CPU/bus reset
//   ready          out  high only in RUN
//   init_timeout   out  sticky: DDR init timed out at least once
//   lock_lost      out  sticky: lock dropped after release began
//   lock_loss_cnt  out  saturating count of lock-loss events
//   state          out  current state encoding
//
// state  | meaning
// HOLD   | all resets asserted, flash held low for FLASH_RST_CYCLES minimum
// STABLE | resets still asserted, waiting for LOCK_STABLE_CYCLES of lock
// WAKE   | flash and PHY released, waiting FLASH_WAKE_CYCLES
// INIT   | controller released, waiting for ddr_init_done (bounded)
// RUN    | everything released, ready
module rstseq
  import rstseq_pkg::*;
#(
  parameter int unsigned FLASH_RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned FLASH_WAKE_CYCLES  = 16,
  parameter int unsigned INIT_TIMEOUT       = 65535
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pll_locked,
  input  logic              trigger_reset,
  input  logic              ddr_init_done,
  output logic              norflash_rst_n,
  output logic              phy_rst,
  output logic              ctl_rst,
  output logic              cpu_rst,
  output logic              ready,
  output logic              init_timeout,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] lock_loss_cnt,
  output logic [2:0]        state
);

  localparam logic [CNT_W-1:0] FRC_TC = CNT_W'(FLASH_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LSC_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FWC_TC = CNT_W'(FLASH_WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ITO_TC = CNT_W'(INIT_TIMEOUT - 1);

  logic lock_s;

  rstseq_sync u_lock_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .d_in    (pll_locked),
    .q_out   (lock_s)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              lost_q, lost_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic              nf_q, nf_d;
  logic              phy_q, phy_d;
  logic              ctl_q, ctl_d;
  logic              cpu_q, cpu_d;
  logic              ready_q, ready_d;

  logic lock_loss;
  logic restart;

  // Losing lock only counts as an event once something has been released;
  // a drop during STABLE just restarts the qualification window.
  assign lock_loss = !lock_s && (state_q inside {ST_WAKE, ST_INIT, ST_RUN});

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    lost_d     = lost_q;
    loss_cnt_d = loss_cnt_q;
    restart    = 1'b0;

    if (lock_loss) begin
      state_d = ST_HOLD;
      lost_d  = 1'b1;
      if (loss_cnt_q != LOSS_MAX) loss_cnt_d = loss_cnt_q + LOSS_W'(1);
    end else if (state_q == ST_STABLE && !lock_s) begin
      state_d = ST_HOLD;
    end else if (trigger_reset) begin
      state_d = ST_HOLD;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        ST_HOLD:   if (cnt_q >= FRC_TC && lock_s) state_d = ST_STABLE;
        ST_STABLE: if (cnt_q == LSC_TC) state_d = ST_WAKE;
        ST_WAKE:   if (cnt_q == FWC_TC) state_d = ST_INIT;
        ST_INIT: begin
          if (ddr_init_done) begin
            state_d = ST_RUN;
          end else if (cnt_q == ITO_TC) begin
            state_d = ST_HOLD;
            tmo_d   = 1'b1;
          end
        end
        ST_RUN:    state_d = ST_RUN;
        default:   state_d = ST_HOLD;
      endcase
    end

    // A trigger while already in HOLD stays in HOLD but still restarts
    // the minimum flash-low window.
    if (restart || state_d != state_q) cnt_d = '0;
    else                               cnt_d = sat_inc(cnt_q);

    // Outputs decode the next state so they register together with it.
    nf_d    = state_d inside {ST_WAKE, ST_INIT, ST_RUN};
    phy_d   = !(state_d inside {ST_WAKE, ST_INIT, ST_RUN});
    ctl_d   = !(state_d inside {ST_INIT, ST_RUN});
    cpu_d   = (state_d != ST_RUN);
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
      nf_q       <= 1'b0;
      phy_q      <= 1'b1;
      ctl_q      <= 1'b1;
      cpu_q      <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
      nf_q       <= nf_d;
      phy_q      <= phy_d;
      ctl_q      <= ctl_d;
      cpu_q      <= cpu_d;
      ready_q    <= ready_d;
    end
  end

  assign norflash_rst_n = nf_q;
  assign phy_rst        = phy_q;
  assign ctl_rst        = ctl_q;
  assign cpu_rst        = cpu_q;
  assign ready          = ready_q;
  assign init_timeout   = tmo_q;
  assign lock_lost      = lost_q;
  assign lock_loss_cnt  = loss_cnt_q;
  assign state          = state_q;

endmodule

// File: tb/tb_rstseq.sv
// tb_rstseq -- self-checking bench for rstseq with a cycle-level reference
// model of the sequencing rules running in lockstep.
module tb_rstseq;

  localparam int FRC = 8;
  localparam int LSC = 32;
  localparam int FWC = 16;
  localparam int ITO = 100;

  localparam logic [17:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0};

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       pll_locked;
  logic       trigger_reset;
  logic       ddr_init_done;
  logic       norflash_rst_n;
  logic       phy_rst;
  logic       ctl_rst;
  logic       cpu_rst;
  logic       ready;
  logic       init_timeout;
  logic       lock_lost;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  rstseq #(
    .FLASH_RST_CYCLES   (FRC),
    .LOCK_STABLE_CYCLES (LSC),
    .FLASH_WAKE_CYCLES  (FWC),
    .INIT_TIMEOUT       (ITO)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .pll_locked     (pll_locked),
    .trigger_reset  (trigger_reset),
    .ddr_init_done  (ddr_init_done),
    .norflash_rst_n (norflash_rst_n),
    .phy_rst        (phy_rst),
    .ctl_rst        (ctl_rst),
    .cpu_rst        (cpu_rst),
    .ready          (ready),
    .init_timeout   (init_timeout),
    .lock_lost      (lock_lost),
    .lock_loss_cnt  (lock_loss_cnt),
    .state          (state)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: phase index, cycles spent in phase, sticky flags,
  // and the last two sampled lock values (the synchronizer delay).
  int          m_st;
  int          m_t;
  int          m_cnt;
  bit          m_tmo;
  bit          m_lost;
  bit          m_hist[2];
  int          bad_cycles = 0;
  logic [17:0] bad_dut;
  logic [17:0] bad_exp;

  function automatic logic [17:0] dut_vec();
    return {norflash_rst_n, phy_rst, ctl_rst, cpu_rst, ready,
            init_timeout, lock_lost, lock_loss_cnt, state};
  endfunction

  // Release level: 0 nothing released, 1 flash/PHY, 2 +ctl, 3 +cpu.
  function automatic logic [17:0] model_vec();
    int lvl;
    lvl = (m_st < 2) ? 0 : m_st - 1;
    return {lvl >= 1, lvl < 1, lvl < 2, lvl < 3, lvl == 3,
            m_tmo, m_lost, 8'(m_cnt), 3'(m_st)};
  endfunction

  task automatic model_step();
    bit ls;
    bit restart;
    int nxt;
    if (sys_rst) begin
      m_st = 0; m_t = 0; m_cnt = 0; m_tmo = 0; m_lost = 0;
      m_hist[0] = 0; m_hist[1] = 0;
      return;
    end
    ls = m_hist[1];
    nxt = m_st;
    restart = 0;
    if (!ls && m_st >= 2) begin
      nxt = 0; m_lost = 1;
      if (m_cnt < 255) m_cnt++;
    end else if (!ls && m_st == 1) begin
      nxt = 0;
    end else if (trigger_reset) begin
      nxt = 0; restart = 1;
    end else begin
      case (m_st)
        0: if (m_t >= FRC - 1 && ls) nxt = 1;
        1: if (m_t == LSC - 1) nxt = 2;
        2: if (m_t == FWC - 1) nxt = 3;
        3: begin
          if (ddr_init_done) nxt = 4;
          else if (m_t == ITO - 1) begin nxt = 0; m_tmo = 1; end
        end
        default: ;
      endcase
    end
    if (restart || nxt != m_st) m_t = 0;
    else if (m_t < 65535) m_t++;
    m_st = nxt;
    m_hist[1] = m_hist[0];
    m_hist[0] = pll_locked;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT saw and
  // any divergence is recorded for the next end-of-task check.
  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
    if (dut_vec() !== model_vec()) begin
      if (bad_cycles == 0) begin
        bad_dut = dut_vec();
        bad_exp = model_vec();
      end
      bad_cycles++;
    end
  endtask

  task automatic wait_state(input int tgt, input int max, output int n, output bit ok);
    n = 0;
    ok = 0;
    while (n < max && !ok) begin
      tick();
      n++;
      if (state === 3'(tgt)) ok = 1;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    pll_locked    = 1'($urandom_range(0, 1));
    trigger_reset = 1'($urandom_range(0, 1));
    ddr_init_done = 1'($urandom_range(0, 1));
    sys_rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (dut_vec() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_values got=%b want=%b", dut_vec(), RST_VEC);
    end
    sys_rst = 1'b0;
    trigger_reset = 1'b0;
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL reset_lockstep bad_cycles=%0d got=%b want=%b", bad_cycles, bad_dut, bad_exp);
      bad_cycles = 0;
    end
  endtask

  task automatic test_sequence();
    int n;
    pll_locked = 1'b1;
    ddr_init_done = 1'b0;
    trigger_reset = 1'b0;
    do_reset();
    n = 0;
    while (norflash_rst_n !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (n != FRC + LSC) begin
      failures++;
      $display("FAIL seq_flash_release cycles=%0d want=%0d", n, FRC + LSC);
    end
    n = 0;
    while (ctl_rst !== 1'b0 && n < 300) begin tick(); n++; end
    checks++;
    if (n != FWC) begin
      failures++;
      $display("FAIL seq_ctl_release cycles=%0d want=%0d", n, FWC);
    end
    repeat (5) tick();
    ddr_init_done = 1'b1;
    tick();
    checks++;
    if ({state, ready, cpu_rst} !== {3'd4, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL seq_run state=%0d ready=%b cpu_rst=%b want state=4 ready=1 cpu_rst=0",
               state, ready, cpu_rst);
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL seq_lockstep bad_cycles=%0d got=%b want=%b", bad_cycles, bad_dut, bad_exp);
      bad_cycles = 0;
    end
  endtask

  task automatic test_stable_glitch();
    int n;
    bit ok;
    pll_locked = 1'b1;
    ddr_init_done = 1'b0;
    do_reset();
    wait_state(1, 100, n, ok);
    // Drop two cycles early so the synchronized low lands at counter 20.
    repeat (18) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_state(0, 10, n, ok);
    checks++;
    if (!ok || lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL glitch_to_hold reached=%0d lock_lost=%b want reached=1 lock_lost=0", ok, lock_lost);
    end
    wait_state(1, 100, n, ok);
    wait_state(2, 100, n, ok);
    checks++;
    if (!ok || n != LSC) begin
      failures++;
      $display("FAIL glitch_stable_len cycles=%0d want=%0d", n, LSC);
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL glitch_lockstep bad_cycles=%0d got=%b want=%b", bad_cycles, bad_dut, bad_exp);
      bad_cycles = 0;
    end
  endtask

  task automatic test_run_lock_loss();
    int n;
    bit ok;
    pll_locked = 1'b1;
    ddr_init_done = 1'b1;
    do_reset();
    wait_state(4, 200, n, ok);
    pll_locked = 1'b0;
    repeat (3) tick();
    checks++;
    if ({state, norflash_rst_n, phy_rst, ctl_rst, cpu_rst, ready} !== {3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL loss_hold state=%0d nf=%b phy=%b ctl=%b cpu=%b rdy=%b want 0 0 1 1 1 0",
               state, norflash_rst_n, phy_rst, ctl_rst, cpu_rst, ready);
    end
    checks++;
    if (lock_lost !== 1'b1 || lock_loss_cnt !== 8'd1) begin
      failures++;
      $display("FAIL loss_flags lock_lost=%b cnt=%0d want 1 1", lock_lost, lock_loss_cnt);
    end
    pll_locked = 1'b1;
    wait_state(4, 300, n, ok);
    checks++;
    if (!ok || ready !== 1'b1) begin
      failures++;
      $display("FAIL loss_reseq reached=%0d ready=%b want 1 1", ok, ready);
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL loss_lockstep bad_cycles=%0d got=%b want=%b", bad_cycles, bad_dut, bad_exp);
      bad_cycles = 0;
    end
  endtask

  task automatic test_init_timeout();
    int n;
    int d;
    bit ok;
    pll_locked = 1'b1;
    ddr_init_done = 1'b0;
    do_reset();
    wait_state(3, 200, n, ok);
    wait_state(0, 200, n, ok);
    checks++;
    if (!ok || n != ITO || init_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout cycles=%0d init_timeout=%b want cycles=%0d init_timeout=1", n, init_timeout, ITO);
    end
    d = $urandom_range(0, 50);
    wait_state(3, 200, n, ok);
    repeat (d) tick();
    ddr_init_done = 1'b1;
    wait_state(4, 10, n, ok);
    checks++;
    if (!ok || init_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_retry reached=%0d init_timeout=%b want 1 1", ok, init_timeout);
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL timeout_lockstep bad_cycles=%0d got=%b want=%b", bad_cycles, bad_dut, bad_exp);
      bad_cycles = 0;
    end
  endtask

  task automatic test_trigger();
    int n;
    int cnt_before;
    int r;
    bit ok;
    pll_locked = 1'b1;
    ddr_init_done = 1'b1;
    wait_state(4, 300, n, ok);
    cnt_before = m_cnt;
    trigger_reset = 1'b1;
    tick();
    trigger_reset = 1'b0;
    checks++;
    if (state !== 3'd0 || norflash_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL trig_hold state=%0d nf=%b want 0 0", state, norflash_rst_n);
    end
    n = 0;
    while (norflash_rst_n !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (n < FRC || n != FRC + LSC) begin
      failures++;
      $display("FAIL trig_flash_low cycles=%0d want=%0d", n, FRC + LSC);
    end
    checks++;
    if (lock_loss_cnt !== 8'(cnt_before)) begin
      failures++;
      $display("FAIL trig_cnt cnt=%0d want=%0d", lock_loss_cnt, cnt_before);
    end
    // Re-trigger partway through HOLD: the flash-low window restarts.
    trigger_reset = 1'b1;
    tick();
    trigger_reset = 1'b0;
    r = $urandom_range(1, FRC - 2);
    repeat (r) tick();
    trigger_reset = 1'b1;
    tick();
    trigger_reset = 1'b0;
    n = 0;
    while (norflash_rst_n !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (n != FRC + LSC) begin
      failures++;
      $display("FAIL trig_restart cycles=%0d want=%0d", n, FRC + LSC);
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL trig_lockstep bad_cycles=%0d got=%b want=%b", bad_cycles, bad_dut, bad_exp);
      bad_cycles = 0;
    end
  endtask

  task automatic test_saturate();
    int n;
    int misses;
    bit ok;
    misses = 0;
    pll_locked = 1'b1;
    ddr_init_done = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_state(2, 200, n, ok);
      if (!ok) misses++;
      repeat ($urandom_range(0, 25)) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_state(0, 5, n, ok);
      if (!ok) misses++;
    end
    checks++;
    if (misses != 0) begin
      failures++;
      $display("FAIL sat_progress missed=%0d want=0", misses);
    end
    checks++;
    if (lock_loss_cnt !== 8'd255 || lock_lost !== 1'b1) begin
      failures++;
      $display("FAIL sat_count cnt=%0d lock_lost=%b want 255 1", lock_loss_cnt, lock_lost);
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL sat_lockstep bad_cycles=%0d got=%b want=%b", bad_cycles, bad_dut, bad_exp);
      bad_cycles = 0;
    end
  endtask

  task automatic test_sysrst_in_init();
    int n;
    bit ok;
    pll_locked = 1'b1;
    ddr_init_done = 1'b0;
    wait_state(3, 300, n, ok);
    sys_rst = 1'b1;
    trigger_reset = 1'b1;
    tick();
    checks++;
    if (!ok || dut_vec() !== RST_VEC) begin
      failures++;
      $display("FAIL sysrst_init reached=%0d got=%b want=%b", ok, dut_vec(), RST_VEC);
    end
    sys_rst = 1'b0;
    trigger_reset = 1'b0;
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL sysrst_lockstep bad_cycles=%0d got=%b want=%b", bad_cycles, bad_dut, bad_exp);
      bad_cycles = 0;
    end
  endtask

  task automatic test_random_soak();
    int runs;
    runs = 0;
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      pll_locked    = ($urandom_range(0, 399) != 0);
      trigger_reset = ($urandom_range(0, 299) == 0);
      ddr_init_done = ($urandom_range(0, 29) == 0);
      sys_rst       = ($urandom_range(0, 1999) == 0);
      tick();
      if (state === 3'd4) runs++;
    end
    sys_rst = 1'b0;
    trigger_reset = 1'b0;
    checks++;
    if (runs == 0) begin
      failures++;
      $display("FAIL soak_reach_run run_cycles=%0d want>0", runs);
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL soak_lockstep bad_cycles=%0d got=%b want=%b", bad_cycles, bad_dut, bad_exp);
      bad_cycles = 0;
    end
  endtask

  initial begin
    sys_rst       = 1'b1;
    pll_locked    = 1'b0;
    trigger_reset = 1'b0;
    ddr_init_done = 1'b0;
    test_reset();
    test_sequence();
    test_stable_glitch();
    test_run_lock_loss();
    test_init_timeout();
    test_trigger();
    test_saturate();
    test_sysrst_in_init();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
